// File: rtl/rr_arbiter_4req_pkg.sv
// Shared constants, state encoding and index decode for the 4-requester round-robin arbiter.
package rr_arbiter_4req_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // 2-to-4 decode of a requester index into a one-hot grant vector
  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage : rr_arbiter_4req_pkg

// File: rtl/rr_pick4.sv
// Round-robin search: first set request bit starting just after the last owner.
module rr_pick4
  import rr_arbiter_4req_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  // Scan from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    logic [ID_W-1:0] idx;
    found = 1'b0;
    id    = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
  end

endmodule : rr_pick4

// File: rtl/rr_arbiter_4req.sv
// Round-robin arbiter for 4 requesters with registered one-hot grant and an enforced
// idle cycle between owners. Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_4req
  import rr_arbiter_4req_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  // Reject a hold limit the counter cannot represent
  if ((MAX_HOLD < 1) || (MAX_HOLD > (32'd1 << CNT_W) - 32'd1)) begin : g_bad_cfg
    $error("rr_arbiter_4req: MAX_HOLD must be in 1 .. 2**CNT_W-1");
  end

  arb_state_e         state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic               gnt_valid_q;
  logic               timeout_q;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   hold_cnt_q;
`endif

  logic               pick_found;
  logic [ID_W-1:0]    pick_id;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .id    (pick_id)
  );

  // Arbitration FSM: grant in IDLE, hold or release (or revoke) in BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            state_q     <= ST_BUSY;
            ptr_q       <= pick_id;
            gnt_q       <= id_to_onehot(pick_id);
            gnt_id_q    <= pick_id;
            gnt_valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (!req[gnt_id_q]) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            // Forced revoke; ptr keeps the revoked id so it drops to lowest priority
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b1;
          end else begin
            hold_cnt_q  <= hold_cnt_q + CNT_W'(1);
          end
`endif
        end
        default: begin
          state_q     <= ST_IDLE;
          gnt_q       <= '0;
          gnt_id_q    <= '0;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule : rr_arbiter_4req

// File: tb/tb_rr_arbiter_4req.sv
// Bench for rr_arbiter_4req: directed scenarios plus randomized traffic against an
// owner/last-owner model. Build with ARB_TIMEOUT_EN defined to exercise the hold limit.
module tb_rr_arbiter_4req;

  localparam int unsigned TB_MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter_4req #(
    .MAX_HOLD (TB_MAX_HOLD),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: who owns the resource, who owned it last, and how long the owner has held it
  int m_owner;
  int m_last;
  int m_age;
  bit m_to;
  int order_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_age   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (r[c]) begin
          m_owner = c;
          m_last  = c;
          m_age   = 1;
          order_q.push_back(c);
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
`ifdef ARB_TIMEOUT_EN
    end else if (m_age == int'(TB_MAX_HOLD)) begin
      m_owner = -1;
      m_to    = 1'b1;
`endif
    end else begin
      m_age++;
    end
  endtask

  task automatic compare_all(input string tag);
    int eg;
    eg = (m_owner < 0) ? 0 : (1 << m_owner);
    check({tag, ".gnt"},       int'(gnt),       eg);
    check({tag, ".gnt_id"},    int'(gnt_id),    (m_owner < 0) ? 0 : m_owner);
    check({tag, ".gnt_valid"}, int'(gnt_valid), (m_owner < 0) ? 0 : 1);
    check({tag, ".timeout"},   int'(timeout),   int'(m_to));
  endtask

  // One clock: model follows the edge, outputs checked 1 time unit later
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_edge(req);
    #1;
    compare_all(tag);
  endtask

  // Async reset asserted between edges, held across one edge, then released
  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge clk);
    #1;
    compare_all({tag, ".held"});
    rst = 1'b0;
  endtask

  // Requests from base; the owner drops its bit after holding for hold cycles
  task automatic run_policy(input logic [3:0] base, input int hold, input int cycles,
                            input string tag);
    for (int i = 0; i < cycles; i++) begin
      logic [3:0] r;
      r = base;
      if (m_owner >= 0 && m_age >= hold) r[m_owner] = 1'b0;
      req = r;
      step(tag);
    end
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check({tag, ".count"}, order_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < order_q.size(); i++)
      check($sformatf("%s.grant%0d", tag, i), order_q[i], exp_q[i]);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    req = 4'b1111;

    // Reset holds all outputs low even with every request up
    #12;
    check("reset.gnt", int'(gnt), 0);
    check("reset.gnt_valid", int'(gnt_valid), 0);
    check("reset.gnt_id", int'(gnt_id), 0);
    check("reset.timeout", int'(timeout), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b0001;
    step("first");
    check("first.lit_gnt", int'(gnt), 1);
    req = 4'b0000;
    step("first_rel");

    // Rotation with all requesters active
    apply_reset("rot");
    order_q.delete();
    run_policy(4'b1111, 3, 19, "rot");
    check_order("rot", '{0, 1, 2, 3, 0});
    req = 4'b0000; step("rot_rel"); step("rot_idle");

    // Fairness between two steady requesters
    apply_reset("fair");
    order_q.delete();
    run_policy(4'b0101, 2, 12, "fair");
    check_order("fair", '{0, 2, 0, 2});
    req = 4'b0000; step("fair_rel"); step("fair_idle");

    // Hold limit
    apply_reset("hold");
    req = 4'b0010;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step("hold");
      check("hold.lit_gnt", int'(gnt), 2);
    end
    step("revoke");
    check("revoke.lit_gnt", int'(gnt), 0);
    check("revoke.lit_timeout", int'(timeout), 1);
    req = 4'b0110;
    step("after_to");
    check("after_to.lit_gnt", int'(gnt), 4);
    check("after_to.lit_timeout", int'(timeout), 0);
`else
    for (int i = 0; i < 20; i++) step("hold");
    check("hold.lit_gnt", int'(gnt), 2);
    check("hold.lit_timeout", int'(timeout), 0);
`endif
    req = 4'b0000; step("hold_rel"); step("hold_idle");

    // Reset in the middle of a grant restarts the search at requester 0
    apply_reset("mid");
    req = 4'b0100;
    step("mid_grant");
    check("mid_grant.lit_gnt", int'(gnt), 4);
    step("mid_hold");
    #2 rst = 1'b1;
    #1;
    check("mid_async.lit_gnt", int'(gnt), 0);
    check("mid_async.lit_valid", int'(gnt_valid), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b1111;
    step("mid_restart");
    check("mid_restart.lit_gnt", int'(gnt), 1);
    check("mid_restart.lit_id", int'(gnt_id), 0);
    req = 4'b0000; step("mid_rel");

    // Owner release coinciding with a new request
    apply_reset("swap");
    req = 4'b0010;
    step("swap_grant");
    step("swap_hold");
    req = 4'b1000;
    step("swap_rel");
    check("swap_rel.lit_gnt", int'(gnt), 0);
    step("swap_new");
    check("swap_new.lit_gnt", int'(gnt), 8);
    check("swap_new.lit_id", int'(gnt_id), 3);
    req = 4'b0000; step("swap_idle");

    // Randomized traffic; owners tend to keep their request up
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      if (i % 700 == 699) apply_reset("rnd_rst");
      r = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      req = r;
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_rr_arbiter_4req
